// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the multiply-accumulate stage.
// Contents: state_t (IDLE/ACCUM/DONE), PROD_W (product width), PROD_MAX
// (largest product the upstream 4x3 multiplier can produce).
package mac_pkg;

  localparam int PROD_W   = 7;
  localparam int PROD_MAX = 105;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_accum_sat_add.sv
// sat_add: W-bit unsigned adder with carry-out.
// Build option: MAC_SAT_EN defined -> sum clamps to all-ones on carry;
//               MAC_SAT_EN undefined -> sum wraps modulo 2^W.
// Ports:
//   i_a, i_b  W-bit operands
//   o_sum     W-bit result (saturated or wrapped)
//   o_carry   carry out of the W-bit addition
module sat_add #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  logic [W:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_full[W];

`ifdef MAC_SAT_EN
  assign o_sum = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
`else
  assign o_sum = w_full[W-1:0];
`endif

endmodule

// File: rtl/mac_accum.sv
// mac_accum: sums N_TERMS consecutive products into an ACC_W-bit result and
// presents it on a valid/ready port with a sticky overflow flag.
// Build option: MAC_SAT_EN (saturating accumulate, see sat_add).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clr                 synchronous abort of any partial/pending result
//   in_valid/in_ready   product handshake, prod = 7-bit unsigned product
//   out_valid/out_ready result handshake
//   out_data            accumulated sum (ACC_W bits)
//   out_ovf             some accumulation step exceeded 2^ACC_W-1
module mac_accum
  import mac_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  state_t           r_state, w_state_nx;
  logic [ACC_W-1:0] r_acc, w_acc_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_ovf, w_ovf_nx;

  logic [ACC_W-1:0] w_add_a, w_add_b, w_sum;
  logic             w_carry;
  logic             w_beat;

  // The first beat of a result starts from zero rather than the old total.
  assign w_add_a = (r_state == IDLE) ? '0 : r_acc;
  assign w_add_b = ACC_W'(prod);

  sat_add #(.W(ACC_W)) u_add (
    .i_a     (w_add_a),
    .i_b     (w_add_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign in_ready  = (r_state != DONE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;
  assign w_beat    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_acc   <= w_acc_nx;
      r_cnt   <= w_cnt_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_cnt_nx   = r_cnt;
    w_ovf_nx   = r_ovf;
    if (clr) begin
      w_state_nx = IDLE;
      w_acc_nx   = '0;
      w_cnt_nx   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_beat) begin
            w_acc_nx   = w_sum;
            w_cnt_nx   = CNT_W'(1);
            w_ovf_nx   = 1'b0;
            w_state_nx = (N_TERMS == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            w_acc_nx = w_sum;
            w_cnt_nx = r_cnt + CNT_W'(1);
            w_ovf_nx = r_ovf | w_carry;
            if ((r_cnt + CNT_W'(1)) == CNT_W'(N_TERMS)) w_state_nx = DONE;
          end
        end
        DONE: begin
          if (out_ready) w_state_nx = IDLE;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed checks of mac_accum in four parameterisations that
// share one stimulus bus: (N=4,W=10), (N=4,W=8), (N=8,W=10), (N=1,W=10).
// Honours MAC_SAT_EN when choosing the expected overflow result.
module tb_mac_accum;
  import mac_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] prod = '0;
  logic       out_ready = 1'b0;

  logic       ir4, ov4, of4;  logic [9:0] od4;
  logic       irw, ovw, ofw;  logic [7:0] odw;
  logic       ir8, ov8, of8;  logic [9:0] od8;
  logic       ir1, ov1, of1;  logic [9:0] od1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accum #(.N_TERMS(4), .ACC_W(10)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir4),
    .prod(prod), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_ovf(of4));
  mac_accum #(.N_TERMS(4), .ACC_W(8)) dutw (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(irw),
    .prod(prod), .out_valid(ovw), .out_ready(out_ready), .out_data(odw), .out_ovf(ofw));
  mac_accum #(.N_TERMS(8), .ACC_W(10)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir8),
    .prod(prod), .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_ovf(of8));
  mac_accum #(.N_TERMS(1), .ACC_W(10)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir1),
    .prod(prod), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ovf(of1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [6:0] p);
    in_valid = 1'b1;
    prod     = p;
    tick();
  endtask

  task automatic reset_pulse();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held
    #12;
    chk("rst_in_ready", ir4, 1);
    chk("rst_out_valid", ov4, 0);
    chk("rst_out_data", od4, 0);
    chk("rst_out_ovf", of4, 0);
    rst = 1'b0;
    tick();

    // Basic sum 1+8+15+14 = 38, N=4
    beat(1); beat(8); beat(15);
    chk("basic_not_yet_valid", ov4, 0);
    beat(14);
    in_valid = 1'b0;
    chk("basic_valid", ov4, 1);
    chk("basic_data", od4, 38);
    chk("basic_ovf", of4, 0);
    chk("basic_in_ready_low", ir4, 0);
    tick();
    chk("basic_hold_valid", ov4, 1);
    chk("basic_hold_in_ready", ir4, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_release_valid", ov4, 0);
    chk("basic_release_in_ready", ir4, 1);

    // Overflow: 4 x 105 = 420 into 8 bits
    reset_pulse();
    tick();
    repeat (4) beat(PROD_MAX[6:0]);
    in_valid = 1'b0;
    chk("ovf_valid", ovw, 1);
`ifdef MAC_SAT_EN
    chk("ovf_data_sat", odw, 255);
`else
    chk("ovf_data_wrap", odw, 164);
`endif
    chk("ovf_flag", ofw, 1);
    chk("ovf_wide_data", od4, 420);
    chk("ovf_wide_flag", of4, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // Next result clears the sticky flag
    repeat (4) beat(1);
    in_valid = 1'b0;
    chk("ovf_cleared_data", odw, 4);
    chk("ovf_cleared_flag", ofw, 0);

    // Bubbles and backpressure, N=8, prod=3
    reset_pulse();
    tick();
    prod = 7'd3;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      if (i == 13) chk("bubble_7beats_not_valid", ov8, 0);
    end
    chk("bubble_valid", ov8, 1);
    chk("bubble_data", od8, 24);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", od8, 24);
      chk("bp_valid", ov8, 1);
      chk("bp_in_ready", ir8, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_release_valid", ov8, 0);
    chk("bp_release_in_ready", ir8, 1);

    // N_TERMS=1: every beat is a result
    reset_pulse();
    tick();
    beat(105);
    chk("n1_valid", ov1, 1);
    chk("n1_data", od1, 105);
    chk("n1_in_ready", ir1, 0);
    out_ready = 1'b1;
    beat(7);
    out_ready = 1'b0;
    chk("n1_idle_valid", ov1, 0);
    chk("n1_idle_in_ready", ir1, 1);
    beat(7);
    in_valid = 1'b0;
    chk("n1_second_valid", ov1, 1);
    chk("n1_second_data", od1, 7);

    // Asynchronous reset after 2 of 4 beats
    reset_pulse();
    tick();
    beat(5); beat(5);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("amid_in_ready", ir4, 1);
    chk("amid_out_valid", ov4, 0);
    chk("amid_out_data", od4, 0);
    chk("amid_out_ovf", of4, 0);
    #1 rst = 1'b0;
    tick();
    repeat (4) beat(2);
    in_valid = 1'b0;
    chk("after_rst_valid", ov4, 1);
    chk("after_rst_data", od4, 8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // clr together with a beat in ACCUM
    beat(10); beat(10);
    clr = 1'b1;
    beat(50);
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_accum_in_ready", ir4, 1);
    chk("clr_accum_valid", ov4, 0);
    chk("clr_accum_data", od4, 0);
    beat(1); beat(2); beat(3); beat(4);
    in_valid = 1'b0;
    chk("clr_clean_valid", ov4, 1);
    chk("clr_clean_data", od4, 10);

    // clr together with out_ready in DONE: result dropped, acc cleared
    clr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b0;
    chk("clr_done_valid", ov4, 0);
    chk("clr_done_in_ready", ir4, 1);
    chk("clr_done_data", od4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
